// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: 100 Hz time base, start/stop/lap/clear FSM,
// BCD mm:ss.cc live count and lap snapshot feeding the SSD multiplexer.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   output logic [23:0] disp_bcd,
   output logic [1:0]  state,
   output logic        running,
   output logic        wrap
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } st_t;

   st_t           cur;
   st_t           nxt;
   logic [PW-1:0] pre;
   logic [23:0]   live;
   logic [23:0]   snap;
   logic [23:0]   live_inc;
   logic          roll;
   logic          active;
   logic          adv;
   logic          tick;
   logic          cap;

   // Command edges never advance time; lap only captures while counting.
   assign active = (cur == RUN) || (cur == LAP);
   assign adv    = active && !start_stop && !clear;
   assign tick   = adv && (pre == PRE_MAX);
   assign cap    = active && lap && !start_stop && !clear;

   // BCD cascade: cs 00-99, s 00-59, m 00-99, roll at 99:59.99.
   always_comb begin
      live_inc = live;
      roll     = 1'b0;
      if (live[3:0] != 4'd9) begin
         live_inc[3:0] = live[3:0] + 4'd1;
      end else begin
         live_inc[3:0] = 4'd0;
         if (live[7:4] != 4'd9) begin
            live_inc[7:4] = live[7:4] + 4'd1;
         end else begin
            live_inc[7:4] = 4'd0;
            if (live[11:8] != 4'd9) begin
               live_inc[11:8] = live[11:8] + 4'd1;
            end else begin
               live_inc[11:8] = 4'd0;
               if (live[15:12] != 4'd5) begin
                  live_inc[15:12] = live[15:12] + 4'd1;
               end else begin
                  live_inc[15:12] = 4'd0;
                  if (live[19:16] != 4'd9) begin
                     live_inc[19:16] = live[19:16] + 4'd1;
                  end else begin
                     live_inc[19:16] = 4'd0;
                     if (live[23:20] != 4'd9) begin
                        live_inc[23:20] = live[23:20] + 4'd1;
                     end else begin
                        live_inc[23:20] = 4'd0;
                        roll            = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= IDLE;
      end else begin
         cur <= nxt;
      end
   end

   // Next state: clear beats start_stop beats lap.
   always_comb begin
      nxt = cur;
      if (clear) begin
         nxt = IDLE;
      end else if (start_stop) begin
         unique case (cur)
            IDLE, PAUSE: nxt = RUN;
            RUN, LAP:    nxt = PAUSE;
            default:     nxt = cur;
         endcase
      end else if (lap && active) begin
         nxt = LAP;
      end
   end

   // Outputs decoded from registers only.
   always_comb begin
      state    = cur;
      running  = active;
      disp_bcd = (cur == LAP) ? snap : live;
   end

   // Prescaler, live count, lap snapshot and wrap pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre  <= '0;
         live <= '0;
         snap <= '0;
         wrap <= 1'b0;
      end else if (clear) begin
         pre  <= '0;
         live <= '0;
         snap <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (tick) begin
            pre  <= '0;
            live <= live_inc;
            wrap <= roll;
         end else if (adv) begin
            pre <= pre + 1'b1;
         end
         if (cap) begin
            snap <= live;
         end
      end
   end

endmodule
